// File: rtl/oled_frame_arbiter.sv
// ---------------------------------------------------------------------------
// oled_frame_arbiter
//   Shares the OLED pixel stream between up to four renderers. One renderer
//   owns the display for a whole frame. Ownership only changes at a frame
//   boundary (index wrapping back to 0), using round-robin rotation with a
//   minimum hold time while other renderers are waiting.
//
// Ports
//   clock        : system clock, shared with the OLED driver
//   reset        : synchronous, active-high reset
//   index        : current pixel index from the OLED driver (0..LAST_INDEX)
//   req          : per-renderer display request, level-sensitive
//   pix0..pix3   : renderer colours (RGB565) for the current index
//   data         : registered pixel colour to the OLED driver
//   grant        : one-hot current owner, 0 when idle
//   owner_valid  : high while a renderer owns the display
//   switch_pulse : one-cycle pulse on the edge where (state, owner) changes
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | nobody owns the display, BLANK_COLOUR is driven
// ST_OWN  | owner_q owns the display, its colour is forwarded
// ---------------------------------------------------------------------------
module oled_frame_arbiter #(
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter logic [15:0] BLANK_COLOUR = 16'h0000,
  parameter int unsigned LAST_INDEX   = 6143,
  localparam int unsigned IDX_W       = $clog2(LAST_INDEX + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic [3:0]       req,
  input  logic [15:0]      pix0,
  input  logic [15:0]      pix1,
  input  logic [15:0]      pix2,
  input  logic [15:0]      pix3,
  output logic [15:0]      data,
  output logic [3:0]       grant,
  output logic             owner_valid,
  output logic             switch_pulse
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic [7:0]       hold_q, hold_d;
  logic [IDX_W-1:0] prev_index_q;
  logic [15:0]      data_q, data_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             switch_q, switch_d;

  logic             frame_start;
  logic             others_req;
  logic [8:0]       hold_inc;

  // First requester strictly after base, wrapping so base itself is
  // examined last.
  function automatic logic [1:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] r);
    logic       found;
    logic [1:0] cand;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  // An index parked at 0 (or 0 right after reset) is not a new frame.
  assign frame_start = (index == '0) && (prev_index_q != '0);
  assign others_req  = |(req & ~(4'b0001 << owner_q));
  assign hold_inc    = {1'b0, hold_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    hold_d       = hold_q;
    last_owner_d = (state_q == ST_OWN) ? owner_q : last_owner_q;

    if (frame_start) begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_d = ST_OWN;
            owner_d = rr_pick(last_owner_q, req);
            hold_d  = 8'd0;
          end
        end
        ST_OWN: begin
          if (req == 4'b0000) begin
            state_d = ST_IDLE;
          end else if (!req[owner_q]) begin
            owner_d = rr_pick(owner_q, req);
            hold_d  = 8'd0;
          end else if ((hold_inc >= 9'(HOLD_FRAMES)) && others_req) begin
            // Owner is examined last by rr_pick, so another requester wins.
            owner_d = rr_pick(owner_q, req);
            hold_d  = 8'd0;
          end else begin
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the values being loaded this edge so that pixel 0 of a
    // new frame already comes from the new owner.
    data_d = BLANK_COLOUR;
    if (state_d == ST_OWN) begin
      unique case (owner_d)
        2'd0:    data_d = pix0;
        2'd1:    data_d = pix1;
        2'd2:    data_d = pix2;
        default: data_d = pix3;
      endcase
    end
    grant_d  = (state_d == ST_OWN) ? (4'b0001 << owner_d) : 4'b0000;
    valid_d  = (state_d == ST_OWN);
    switch_d = (state_d != state_q) || (owner_d != owner_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      hold_q       <= 8'd0;
      prev_index_q <= '0;
      data_q       <= BLANK_COLOUR;
      grant_q      <= 4'b0000;
      valid_q      <= 1'b0;
      switch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      prev_index_q <= index;
      data_q       <= data_d;
      grant_q      <= grant_d;
      valid_q      <= valid_d;
      switch_q     <= switch_d;
    end
  end

  assign data         = data_q;
  assign grant        = grant_q;
  assign owner_valid  = valid_q;
  assign switch_pulse = switch_q;

endmodule

// File: doc/oled_frame_arbiter.md
Name: oled_frame_arbiter

Overview:
- Shares the 96x64 OLED pixel stream between up to four soundbar/visualiser renderers.
- Each renderer produces a 16-bit RGB565 colour for the current pixel index.
- The arbiter grants one renderer per frame, with round-robin rotation and a minimum hold time.
- Ownership changes only at frame boundaries, so no frame ever shows mixed sources. It sits between the renderers and the OLED driver's pixel_data input.

Parameters:
- HOLD_FRAMES, 8: minimum frames an owner keeps the display while others request; legal range 1..255.
- BLANK_COLOUR, 16'h0000: colour driven while no renderer owns the display.
- LAST_INDEX, 6143: final pixel index of a frame (96*64-1).

Ports:
- clock  input  1  system clock, same clock as the OLED driver.
- reset  input  1  synchronous, active-high reset.
- index  input  13  current pixel index from the OLED driver, 0..LAST_INDEX.
- req  input  4  per-renderer display request, level-sensitive.
- pix0  input  16  renderer 0 colour for the current index.
- pix1  input  16  renderer 1 colour for the current index.
- pix2  input  16  renderer 2 colour for the current index.
- pix3  input  16  renderer 3 colour for the current index.
- data  output  16  registered pixel colour to the OLED driver.
- grant  output  4  one-hot current owner; 0 when idle.
- owner_valid  output  1  high while in the OWN state.
- switch_pulse  output  1  one-cycle pulse on the edge where the owner changes, including idle to own and own to idle.

Behaviour:
- Registered state: state (IDLE, OWN), owner[1:0], last_owner[1:0], hold_cnt[7:0], prev_index[12:0].
- Reset values: state=IDLE, owner=0, last_owner=3 (so the first grant search starts at renderer 0), hold_cnt=0, prev_index=0, data=BLANK_COLOUR, grant=0, owner_valid=0, switch_pulse=0.
- prev_index <= index every cycle.
- frame_start = (index==0) && (prev_index!=0).
  - A held index of 0 never retriggers.
  - An index==0 on the first cycle after reset is not a boundary.
- All arbitration decisions are made only on cycles where frame_start=1. On all other cycles, state, owner and hold_cnt hold.
- Round-robin search, RR(base): the first set bit of req examined in order base+1, base+2, base+3, base (mod 4).
- Transitions at frame_start:
  - IDLE, req==0: stay IDLE.
  - IDLE, req!=0: state=OWN, owner=RR(last_owner), hold_cnt=0.
  - OWN, req[owner]==0, others requesting: owner=RR(owner), hold_cnt=0.
  - OWN, req==0: state=IDLE, last_owner=owner.
  - OWN, req[owner]==1, hold_cnt+1 >= HOLD_FRAMES, another bit set: owner moves to the next requester after the current owner (the current owner is skipped), hold_cnt=0.
  - OWN, otherwise: hold_cnt = hold_cnt+1, saturating at 255.
- last_owner tracks owner whenever state=OWN.
- Output timing: one cycle latency. On each edge, data <= pix[next_owner] if next_state==OWN, else BLANK_COLOUR. next_* are the values being loaded this edge, so pixel index 0 of a new frame already comes from the new owner.
- grant and owner_valid are registered copies of next_owner/next_state, aligned with data.
- switch_pulse=1 for exactly the edge where the (state, owner) pair changes value.
- Request changes between boundaries have no effect on data or grant.
- Reset asserted mid-frame: all outputs return to reset values on the next edge; arbitration resumes at the next genuine frame_start.

Test Plan:
- Reset, then index sweeps 0..6143 twice with req=0 -> data=16'h0000 throughout, grant=0, switch_pulse never asserted.
- req=4'b0100, pix2=16'hF800, sweep to wrap -> at the edge after index 0: grant=4'b0100, data=F800, switch_pulse high for 1 cycle. The prior partial frame stays 0000.
- req=4'b0011, HOLD_FRAMES=2, pix0=001F, pix1=07E0 -> renderer 0 owns frames 1-2, renderer 1 owns frames 3-4, renderer 0 again from frame 5; switches occur only at index 0.
- Owner 1 drops req at index 3000 while req[3]=1 -> data stays pix1 until wrap, then grant=4'b1000 with hold_cnt reset.
- All req drop mid-frame -> owner kept until boundary, then IDLE, data=BLANK_COLOUR, last_owner kept. Next request from 2 and 3 -> grant picks RR(last_owner).
- Reset pulsed at index 4000 during OWN -> next cycle data=0000, grant=0. An index frozen at 0 produces no grant until index leaves 0 and returns.
